rr_mux_select_arbiter: RTL

- Round-robin arbiter that drives the 2-bit select of the 4:1 bit multiplexer, directly upstream of it.
- Four requesters raise req bits. The arbiter grants one at a time and holds the select stable for the grant duration.
- A grant ends on consumer done, on requester drop, or on hold timeout. Priority then rotates past the last winner.

---
 rtl/rr_mux_select_arbiter_pkg.sv | 13 +
 rtl/rr_mux_select_arbiter_priority_pick.sv | 29 ++
 rtl/rr_mux_select_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/rr_mux_select_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin select arbiter
// and the 4:1 bit multiplexer it drives.
package rr_mux_select_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_mux_select_arbiter_priority_pick.sv
// Combinational round-robin pick: first set request bit searching
// last+1, last+2, last+3, last (modulo NUM_REQ).
module rr_priority_pick
  import rr_mux_select_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the loop leaves it unassigned (which would infer a latch).
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + SEL_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_select_arbiter.sv
// Round-robin arbiter producing the registered select for a 4:1 bit mux;
// grants end on done, requester drop or hold timeout, with one idle bubble.
module rr_mux_select_arbiter
  import rr_mux_select_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [SEL_W-1:0]   control,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt, cnt_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SEL_W-1:0]   control_d;
  logic [NUM_REQ-1:0] grant_d;
  logic               grant_valid_d, timeout_d;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               release_grant;

  rr_priority_pick u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign release_grant = done || !req[control] || (hold_cnt == MAX_CNT);

  always_comb begin
    state_d       = state_q;
    cnt_d         = hold_cnt;
    last_d        = last_q;
    control_d     = control;
    grant_d       = grant;
    grant_valid_d = grant_valid;
    timeout_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d       = GRANTED;
          control_d     = pick_idx;
          grant_d       = NUM_REQ'(1) << pick_idx;
          grant_valid_d = 1'b1;
          cnt_d         = CNT_W'(1);
        end
      end
      GRANTED: begin
        if (release_grant) begin
          // control is left untouched so the mux output stays put through the bubble
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          last_d        = control;
          cnt_d         = '0;
          timeout_d     = !done && req[control];
        end else if (hold_cnt != MAX_CNT) begin
          cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      hold_cnt    <= '0;
      last_q      <= SEL_W'(NUM_REQ - 1);
      control     <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt    <= cnt_d;
      last_q      <= last_d;
      control     <= control_d;
      grant       <= grant_d;
      grant_valid <= grant_valid_d;
      timeout     <= timeout_d;
    end
  end

endmodule
